// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush sequencer: load-use and branch hazards, dmem freeze,
// memory-timeout fault and saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             id_ex_hold,
    output logic             ex_mem_hold,
    output logic             mem_wb_bubble,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_VAL = 16'(MEM_TIMEOUT);

    state_t           state_reg;
    logic [15:0]      wait_cnt_reg;
    logic             err_reg;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    logic             mem_waiting;
    logic             freeze;
    logic             branch;
    logic             load_use_hit;
    logic             load_use;

    assign mem_waiting  = mem_req && !mem_ready;
    assign freeze       = (state_reg == FAULT) || mem_waiting;
    assign branch       = !freeze && ex_branch_taken;
    assign load_use_hit = ex_mem_read && (ex_rd != 5'd0) &&
                          ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                           (id_uses_rs2 && (id_rs2 == ex_rd)));
    // A taken branch squashes the ID instruction, so its hazard is moot.
    assign load_use     = !freeze && !branch && load_use_hit;

    always_comb begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        id_ex_hold     = 1'b0;
        ex_mem_hold    = 1'b0;
        mem_wb_bubble  = 1'b0;
        if (!reset_n) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            if_id_flush    = 1'b1;
            id_ex_bubble   = 1'b1;
            mem_wb_bubble  = 1'b1;
        end else if (freeze) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_hold     = 1'b1;
            ex_mem_hold    = 1'b1;
            mem_wb_bubble  = 1'b1;
        end else if (branch) begin
            if_id_flush    = 1'b1;
            id_ex_bubble   = 1'b1;
        end else if (load_use) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= RUN;
            wait_cnt_reg  <= 16'd0;
            err_reg       <= 1'b0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (!pc_write_en && (stall_cnt_reg != {CNT_W{1'b1}}))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            if (branch && (flush_cnt_reg != {CNT_W{1'b1}}))
                flush_cnt_reg <= flush_cnt_reg + 1'b1;

            case (state_reg)
                RUN: begin
                    if (mem_waiting) begin
                        state_reg    <= MEM_WAIT;
                        wait_cnt_reg <= 16'd1;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_waiting) begin
                        state_reg    <= RUN;
                        wait_cnt_reg <= 16'd0;
                    end else if (wait_cnt_reg == TIMEOUT_VAL) begin
                        state_reg <= FAULT;
                        err_reg   <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 16'd1;
                    end
                end
                FAULT: begin
                    state_reg <= FAULT;
                end
                default: begin
                    state_reg    <= RUN;
                    wait_cnt_reg <= 16'd0;
                end
            endcase
        end
    end

    assign mem_timeout_err = err_reg;
    assign stall_cnt       = stall_cnt_reg;
    assign flush_cnt       = flush_cnt_reg;

endmodule
